// File: rtl/panda_pkg.sv
// Constants shared by the free list, the ROB and the map table.
package panda_pkg;

    localparam int                  PR_TAG_W      = 7;
    localparam logic [PR_TAG_W-1:0] TAG_INVALID   = 7'h7f;
    localparam int                  FL_DEPTH      = 64;
    localparam int                  NUM_ARCH_REGS = 32;

    // Per-cycle lane counts are 0..2; an encoded 3 behaves as 2.
    function automatic logic [1:0] clamp2(input logic [1:0] n);
        return (n == 2'd3) ? 2'd2 : n;
    endfunction

endpackage

// File: rtl/free_list.sv
// Physical-tag free list: circular FIFO handing out up to two tags per cycle
// and accepting up to two retired tags per cycle, with a sticky misuse flag.
module free_list #(
    parameter int FL_DEPTH      = panda_pkg::FL_DEPTH,
    parameter int PR_FIRST_FREE = panda_pkg::NUM_ARCH_REGS
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [1:0]                     id_dispatch_num,
    input  logic [1:0]                     rob_retire_num,
    input  logic [panda_pkg::PR_TAG_W-1:0] rob_retire_tag_a,
    input  logic [panda_pkg::PR_TAG_W-1:0] rob_retire_tag_b,
    output logic [panda_pkg::PR_TAG_W-1:0] fl_pr0,
    output logic [panda_pkg::PR_TAG_W-1:0] fl_pr1,
    output logic [1:0]                     fl_cap,
    output logic                           fl_error
);
    import panda_pkg::PR_TAG_W;
    import panda_pkg::TAG_INVALID;
    import panda_pkg::clamp2;

    localparam int PTR_W = $clog2(FL_DEPTH);
    localparam int CNT_W = $clog2(FL_DEPTH + 1);

    logic [PR_TAG_W-1:0] entry_q [FL_DEPTH];
    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d, head_p1;
    logic [PTR_W-1:0]    wr_ptr_a, wr_ptr_b;
    logic [CNT_W-1:0]    count_q, count_d, cnt_after, room;
    logic                fl_error_q, fl_error_d;
    logic [1:0]          disp_num, ret_num, alloc, nfree;
    logic                over_alloc, over_free;
    logic                a_req, b_req, wr_a, wr_b;

    assign head_p1 = head_q + PTR_W'(1);
    assign fl_cap  = (count_q == '0)         ? 2'd0 :
                     (count_q == CNT_W'(1))  ? 2'd1 : 2'd2;
    assign fl_pr0  = (count_q == '0)         ? TAG_INVALID : entry_q[head_q];
    assign fl_pr1  = (count_q < CNT_W'(2))   ? TAG_INVALID : entry_q[head_p1];
    assign fl_error = fl_error_q;

    always_comb begin
        disp_num   = clamp2(id_dispatch_num);
        ret_num    = clamp2(rob_retire_num);
        over_alloc = (disp_num > fl_cap);
        alloc      = over_alloc ? fl_cap : disp_num;

        // Room is measured after this cycle's allocation, so a full list can
        // still absorb a retire in the same cycle it hands a tag out.
        cnt_after  = count_q - CNT_W'(alloc);
        room       = CNT_W'(FL_DEPTH) - cnt_after;

        a_req      = (ret_num >= 2'd1) && (rob_retire_tag_a != TAG_INVALID);
        b_req      = (ret_num == 2'd2) && (rob_retire_tag_b != TAG_INVALID);
        wr_a       = a_req && (room != '0);
        wr_b       = b_req && (room > CNT_W'(wr_a));
        over_free  = (a_req && !wr_a) || (b_req && !wr_b);

        // An invalid slot-a tag lets tag b take the tail slot directly.
        wr_ptr_a   = tail_q;
        wr_ptr_b   = tail_q + PTR_W'(wr_a);
        nfree      = {1'b0, wr_a} + {1'b0, wr_b};

        head_d     = head_q + PTR_W'(alloc);
        tail_d     = tail_q + PTR_W'(nfree);
        count_d    = cnt_after + CNT_W'(nfree);
        fl_error_d = fl_error_q | over_alloc | over_free;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= CNT_W'(FL_DEPTH);
            fl_error_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            fl_error_q <= fl_error_d;
        end
    end

    for (genvar gi = 0; gi < FL_DEPTH; gi++) begin : g_entry
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                entry_q[gi] <= PR_TAG_W'(PR_FIRST_FREE + gi);
            end else if (wr_a && (wr_ptr_a == PTR_W'(gi))) begin
                entry_q[gi] <= rob_retire_tag_a;
            end else if (wr_b && (wr_ptr_b == PTR_W'(gi))) begin
                entry_q[gi] <= rob_retire_tag_b;
            end
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Directed and scoreboarded checks of the free list: reset image, drain,
// no-bypass retire, over-allocation, over-free, random wrap traffic, mid-run reset.
module tb_free_list;
    import panda_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] id_dispatch_num  = '0;
    logic [1:0] rob_retire_num   = '0;
    logic [6:0] rob_retire_tag_a = '0;
    logic [6:0] rob_retire_tag_b = '0;
    logic [6:0] fl_pr0, fl_pr1;
    logic [1:0] fl_cap;
    logic       fl_error;

    int errors = 0;
    int checks = 0;

    free_list dut (
        .clock            (clock),
        .reset            (reset),
        .id_dispatch_num  (id_dispatch_num),
        .rob_retire_num   (rob_retire_num),
        .rob_retire_tag_a (rob_retire_tag_a),
        .rob_retire_tag_b (rob_retire_tag_b),
        .fl_pr0           (fl_pr0),
        .fl_pr1           (fl_pr1),
        .fl_cap           (fl_cap),
        .fl_error         (fl_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Returns 1 ns after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic show(input string what);
        $display("[%0t] %-10s disp=%0d ret=%0d a=%0d b=%0d -> pr0=%0d pr1=%0d cap=%0d cnt=%0d err=%0b",
                 $time, what, id_dispatch_num, rob_retire_num, rob_retire_tag_a, rob_retire_tag_b,
                 fl_pr0, fl_pr1, fl_cap, dut.count_q, fl_error);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int       fq[$];
        int       live[$];
        bit       live_flag [128];
        int       fr [2];
        int       d, n, de, cap, a, idx, t;
        logic     err_m;

        // Reset image is visible while reset is still held.
        #12;
        chk("rst_pr0", fl_pr0, 32);
        chk("rst_pr1", fl_pr1, 33);
        chk("rst_cap", fl_cap, 2);
        reset = 1'b1;
        step();
        step();
        show("idle");
        chk("idle_pr0", fl_pr0, 32);
        chk("idle_pr1", fl_pr1, 33);
        chk("idle_cap", fl_cap, 2);
        chk("idle_cnt", dut.count_q, 64);
        chk("idle_err", fl_error, 0);

        // Drain two per cycle; head wraps back to 0.
        id_dispatch_num = 2'd2;
        for (int k = 0; k < 32; k++) begin
            chk("drain_pr0", fl_pr0, 32 + 2 * k);
            step();
        end
        id_dispatch_num = 2'd0;
        show("drained");
        chk("empty_cnt", dut.count_q, 0);
        chk("empty_pr0", fl_pr0, 7'h7f);
        chk("empty_pr1", fl_pr1, 7'h7f);
        chk("empty_cap", fl_cap, 0);
        chk("empty_err", fl_error, 0);

        // Retired tags must not bypass to the outputs in the same cycle.
        rob_retire_num = 2'd2; rob_retire_tag_a = 7'd5; rob_retire_tag_b = 7'd9;
        #1;
        chk("nobyp_pr0", fl_pr0, 7'h7f);
        step();
        rob_retire_num = 2'd0;
        show("retire");
        chk("ret_pr0", fl_pr0, 5);
        chk("ret_pr1", fl_pr1, 9);
        chk("ret_cap", fl_cap, 2);

        // Invalid tag is a no-op.
        rob_retire_num = 2'd1; rob_retire_tag_a = 7'h7f;
        step();
        rob_retire_num = 2'd0;
        show("inv_tag");
        chk("inv_cnt", dut.count_q, 2);
        chk("inv_pr1", fl_pr1, 9);

        id_dispatch_num = 2'd1;
        step();
        id_dispatch_num = 2'd0;
        show("disp1");
        chk("one_cnt", dut.count_q, 1);
        chk("one_pr0", fl_pr0, 9);

        // Over-allocation with simultaneous retire.
        id_dispatch_num = 2'd2;
        rob_retire_num = 2'd2; rob_retire_tag_a = 7'd40; rob_retire_tag_b = 7'd41;
        step();
        id_dispatch_num = 2'd0; rob_retire_num = 2'd0;
        show("overalloc");
        chk("ovr_cnt", dut.count_q, 2);
        chk("ovr_err", fl_error, 1);
        chk("ovr_pr0", fl_pr0, 40);
        chk("ovr_pr1", fl_pr1, 41);

        reset = 1'b0;
        #1;
        chk("rst2_err", fl_error, 0);
        reset = 1'b1;
        step();

        // Random traffic against a FIFO scoreboard.
        for (int i = 0; i < 64; i++) fq.push_back(32 + i);
        for (int i = 0; i < 128; i++) live_flag[i] = 1'b0;
        err_m = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            d = $urandom_range(0, 3);
            n = $urandom_range(0, 2);
            if (n > live.size()) n = live.size();
            fr[0] = 0; fr[1] = 0;
            for (int j = 0; j < n; j++) begin
                idx = $urandom_range(0, live.size() - 1);
                fr[j] = live[idx];
                live.delete(idx);
            end
            id_dispatch_num  = 2'(d);
            rob_retire_num   = 2'(n);
            rob_retire_tag_a = 7'(fr[0]);
            rob_retire_tag_b = 7'(fr[1]);
            #1;
            cap = (fq.size() >= 2) ? 2 : fq.size();
            chk("rnd_cap", fl_cap, cap);
            chk("rnd_pr0", fl_pr0, (fq.size() > 0) ? fq[0] : 7'h7f);
            chk("rnd_pr1", fl_pr1, (fq.size() > 1) ? fq[1] : 7'h7f);
            show("rand");
            de = (d == 3) ? 2 : d;
            a  = (de > cap) ? cap : de;
            if (de > cap) err_m = 1'b1;
            for (int j = 0; j < a; j++) begin
                t = (j == 0) ? int'(fl_pr0) : int'(fl_pr1);
                chk("rnd_dup", live_flag[t], 0);
                live_flag[t] = 1'b1;
                live.push_back(fq.pop_front());
            end
            step();
            for (int j = 0; j < n; j++) begin
                live_flag[fr[j]] = 1'b0;
                fq.push_back(fr[j]);
            end
            chk("rnd_err", fl_error, err_m);
        end
        id_dispatch_num = 2'd0; rob_retire_num = 2'd0;
        chk("rnd_cnt", dut.count_q, fq.size());

        // Over-free at full depth is dropped and flagged.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        step();
        rob_retire_num = 2'd1; rob_retire_tag_a = 7'd100;
        step();
        rob_retire_num = 2'd0;
        show("overfree");
        chk("ofr_cnt", dut.count_q, 64);
        chk("ofr_err", fl_error, 1);
        chk("ofr_pr0", fl_pr0, 32);

        // Bring count to 17, then reset in the middle of live traffic.
        id_dispatch_num = 2'd2;
        for (int k = 0; k < 23; k++) step();
        id_dispatch_num = 2'd1;
        step();
        show("to17");
        chk("c17_cnt", dut.count_q, 17);
        id_dispatch_num = 2'd2;
        rob_retire_num = 2'd1; rob_retire_tag_a = 7'd20;
        #2;
        reset = 1'b0;
        #1;
        show("midreset");
        chk("mid_cnt", dut.count_q, 64);
        chk("mid_pr0", fl_pr0, 32);
        chk("mid_err", fl_error, 0);
        step();
        chk("hold_cnt", dut.count_q, 64);
        id_dispatch_num = 2'd0; rob_retire_num = 2'd0;
        reset = 1'b1;
        step();
        chk("post_pr1", fl_pr1, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter FL_DEPTH, default 64, the number of free-list entries.
REQ-002 SHALL have parameter PR_FIRST_FREE, default 32, the first physical tag free at reset; tags 0..31 back the architectural map.
REQ-003 SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port id_dispatch_num, input, 2 bits, tags consumed this cycle (0, 1 or 2; 3 is treated as 2).
REQ-006 SHALL have port rob_retire_num, input, 2 bits, tags returned this cycle (0, 1 or 2; 3 is treated as 2).
REQ-007 SHALL have port rob_retire_tag_a, input, 7 bits, first returned tag.
REQ-008 SHALL have port rob_retire_tag_b, input, 7 bits, second returned tag.
REQ-009 SHALL have port fl_pr0, output, 7 bits, next tag to allocate, or 7'h7f if none.
REQ-010 SHALL have port fl_pr1, output, 7 bits, tag after fl_pr0, or 7'h7f if fewer than 2 are free.
REQ-011 SHALL have port fl_cap, output, 2 bits, min(free count, 2).
REQ-012 SHALL have port fl_error, output, 1 bit, sticky over-allocation or over-free flag.

Function
REQ-013 SHALL hold tags in a circular FIFO of FL_DEPTH 7-bit entries with 6-bit head and tail pointers and a 7-bit count (0..64).
REQ-014 SHALL derive fl_pr0 and fl_pr1 combinationally from entries head and head+1 (mod 64).
REQ-015 SHALL derive fl_cap combinationally from count: 0 gives 0, 1 gives 1, 2 or more gives 2.
REQ-016 SHALL drive fl_pr0 to 7'h7f when count==0, and fl_pr1 to 7'h7f when count<2.
REQ-017 SHALL compute alloc = min(id_dispatch_num, fl_cap); head advances by alloc, wrapping 63 to 0.
REQ-018 SHALL write rob_retire_tag_a at tail when rob_retire_num>=1, and rob_retire_tag_b at tail+1 when rob_retire_num>=2; tail advances by the write count, with wrap.
REQ-019 SHALL update count <= count - alloc + frees when both happen in the same cycle.
REQ-020 SHALL NOT bypass: tags freed in cycle N appear on fl_pr0/fl_pr1 no earlier than cycle N+1.
REQ-021 SHALL treat a 7'h7f returned tag as a no-op: no write and no pointer or count change for that slot.
REQ-022 SHALL set fl_error when id_dispatch_num > fl_cap; the excess allocation is dropped.
REQ-023 SHALL set fl_error when count - alloc + frees > FL_DEPTH; the excess free is dropped and count saturates at 64.
REQ-024 SHALL allow simultaneous full-depth wrap of both pointers, including head==tail at both count==0 and count==64; count disambiguates.

Reset
REQ-025 SHALL, while reset is low, asynchronously set entry i to PR_FIRST_FREE+i, head=0, tail=0, count=64 and fl_error=0.
REQ-026 SHALL, during reset, produce fl_pr0=32, fl_pr1=33 and fl_cap=2.
REQ-027 SHALL abandon any in-flight allocate or free when reset is asserted mid-operation; no partial update survives.

Structure
REQ-028 SHALL take PR_TAG_W=7, TAG_INVALID=7'h7f, FL_DEPTH and NUM_ARCH_REGS=32 from the shared panda package, also used by rob and the map table.
REQ-029 SHALL be a single module with no sub-module; pointer and count arithmetic is inline.

Verification
REQ-030 Bench SHALL check: release reset, no traffic -> fl_pr0=32, fl_pr1=33, fl_cap=2, count=64.
REQ-031 Bench SHALL check: dispatch 2 for 32 cycles -> count=0, fl_pr0=fl_pr1=7'h7f, fl_cap=0, fl_error=0.
REQ-032 Bench SHALL check: from empty, retire tags 5 and 9 in cycle N -> fl_pr0=7'h7f in cycle N; fl_pr0=5, fl_pr1=9, fl_cap=2 in cycle N+1.
REQ-033 Bench SHALL check: count=1, dispatch 2 and retire 2 (tags 40, 41) in the same cycle -> alloc=1, count=2, fl_error=1.
REQ-034 Bench SHALL check: 200 cycles of random dispatch and retire with pointer wrap -> allocated tag sequence equals retired order plus initial 32..95, and no duplicate tag is live.
REQ-035 Bench SHALL check: assert reset mid-traffic with count=17 -> immediately count=64, fl_pr0=32, fl_error=0.
